// File: rtl/tx_frame_scheduler_pkg.sv
// rtl/tx_frame_scheduler_pkg.sv - shared state encodings, requester indices and helpers for the TX frame scheduler
package tx_frame_scheduler_pkg;

    // One-hot scheduler states
    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_BUILD   = 5'b00010,
        S_RELEASE = 5'b00100,
        S_TX      = 5'b01000,
        S_WAIT    = 5'b10000
    } sched_state_e;

    // Builder slots on the request vector
    localparam int ARP_IDX  = 0;
    localparam int ICMP_IDX = 1;
    localparam int UDP_IDX  = 2;

    // Frame length width in bytes and RAM port b geometry
    localparam int LEN_W_DEF = 11;
    localparam int RAM_AW    = 10;
    localparam int RAM_DW    = 8;

    // Candidate index k positions after the last-served slot, wrapping at n
    function automatic int rr_next(input int last, input int k, input int n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// rtl/tx_frame_scheduler_rr_arbiter.sv - combinational round-robin pick starting after the last-served index
module tx_frame_scheduler_rr_arbiter
    import tx_frame_scheduler_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the farthest candidate to the nearest so the nearest pending slot overwrites the rest
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (pending_i[IDX_W'(rr_next(int'(last_i), k, N_REQ))]) begin
                idx_o    = IDX_W'(rr_next(int'(last_i), k, N_REQ));
                winner_o = {{(N_REQ-1){1'b0}}, 1'b1} << idx_o;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - grants frame RAM port b to one builder at a time and hands finished frames to the TX engine; optional build watchdog under TX_SCHED_WATCHDOG_EN
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int N_REQ = 3,
`ifdef TX_SCHED_WATCHDOG_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                      iDm9000aClk,
    input  logic                      iRst_n,
    input  logic [N_REQ-1:0]          iReq,
    input  logic [N_REQ*LEN_W-1:0]    iLen,
    output logic [N_REQ-1:0]          oRunStart,
    input  logic [N_REQ-1:0]          iRunEnd,
    input  logic [N_REQ-1:0]          iWren,
    input  logic [N_REQ*RAM_DW-1:0]   iData,
    input  logic [N_REQ*RAM_AW-1:0]   iAddr,
    output logic                      wren_b,
    output logic [RAM_DW-1:0]         data_b,
    output logic [RAM_AW-1:0]         address_b,
    output logic                      oTxStart,
    output logic [LEN_W-1:0]          oTxLen,
    input  logic                      iTxDone,
    output logic                      oBusy,
`ifdef TX_SCHED_WATCHDOG_EN
    output logic                      oBuildTimeout,
`endif
    output logic [N_REQ-1:0]          oGrant
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_e       state_q;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   run_q;
    logic               tx_start_q;
    logic [LEN_W-1:0]   tx_len_q;
    logic               busy_q;

    logic [N_REQ-1:0]   arb_winner;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [LEN_W-1:0]   len_arr  [N_REQ];
    logic [RAM_DW-1:0]  data_arr [N_REQ];
    logic [RAM_AW-1:0]  addr_arr [N_REQ];

`ifdef TX_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]    wd_cnt_q;
    logic               timed_out_q;
    logic               timeout_pulse_q;
    assign oBuildTimeout = timeout_pulse_q;
`endif

    // Unpack the flat per-builder buses into indexable views
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign len_arr[g]  = iLen[g*LEN_W +: LEN_W];
        assign data_arr[g] = iData[g*RAM_DW +: RAM_DW];
        assign addr_arr[g] = iAddr[g*RAM_AW +: RAM_AW];
    end

    tx_frame_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .pending_i (pending_q),
        .last_i    (last_q),
        .winner_o  (arb_winner),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    // New requests always land; the granted slot is cleared only in its grant cycle, and a fresh request wins
    always_comb begin
        pending_d = pending_q | iReq;
        if (state_q == S_IDLE && arb_valid) begin
            pending_d = (pending_q & ~arb_winner) | iReq;
        end
    end

    // Pending request register
    always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Port b follows the owner only while it is building; otherwise held at zero so RAM cannot be disturbed
    always_comb begin
        wren_b    = 1'b0;
        data_b    = '0;
        address_b = '0;
        if (state_q == S_BUILD) begin
            wren_b    = iWren[grant_idx_q];
            data_b    = data_arr[grant_idx_q];
            address_b = addr_arr[grant_idx_q];
        end
    end

    // Scheduler FSM with registered grant, run-start, TX handshake and busy outputs
    always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q         <= S_IDLE;
            last_q          <= IDX_W'(N_REQ - 1);
            grant_idx_q     <= '0;
            grant_q         <= '0;
            run_q           <= '0;
            tx_start_q      <= 1'b0;
            tx_len_q        <= '0;
            busy_q          <= 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
            wd_cnt_q        <= '0;
            timed_out_q     <= 1'b0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
            timeout_pulse_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_idx_q <= arb_idx;
                        grant_q     <= arb_winner;
                        run_q       <= arb_winner;
                        tx_len_q    <= len_arr[arb_idx];
                        busy_q      <= 1'b1;
                        state_q     <= S_BUILD;
`ifdef TX_SCHED_WATCHDOG_EN
                        wd_cnt_q    <= '0;
                        timed_out_q <= 1'b0;
`endif
                    end
                end
                S_BUILD: begin
                    if (iRunEnd[grant_idx_q]) begin
                        run_q   <= '0;
                        state_q <= S_RELEASE;
                    end
`ifdef TX_SCHED_WATCHDOG_EN
                    else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        run_q           <= '0;
                        timed_out_q     <= 1'b1;
                        timeout_pulse_q <= 1'b1;
                        state_q         <= S_RELEASE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                S_RELEASE: begin
`ifdef TX_SCHED_WATCHDOG_EN
                    if (tx_len_q == '0 || timed_out_q) begin
`else
                    if (tx_len_q == '0) begin
`endif
                        last_q  <= grant_idx_q;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tx_start_q <= 1'b1;
                        state_q    <= S_TX;
                    end
                end
                S_TX: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (iTxDone) begin
                        last_q  <= grant_idx_q;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    run_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oRunStart = run_q;
    assign oGrant    = grant_q;
    assign oTxStart  = tx_start_q;
    assign oTxLen    = tx_len_q;
    assign oBusy     = busy_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - self-checking bench for tx_frame_scheduler with a transaction-level reference model
module tb_tx_frame_scheduler;
    import tx_frame_scheduler_pkg::*;

    localparam int N  = 3;
    localparam int LW = 11;
    localparam int P_IDLE = 0, P_BUILD = 1, P_REL = 2, P_TX = 3, P_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  iReq;
    logic [32:0] iLen;
    logic [2:0]  oRunStart, iRunEnd, iWren, oGrant;
    logic [23:0] iData;
    logic [29:0] iAddr;
    logic        wren_b, oTxStart, oBusy, tx_done;
    logic [7:0]  data_b;
    logic [9:0]  address_b;
    logic [10:0] oTxLen;
`ifdef TX_SCHED_WATCHDOG_EN
    logic        oBuildTimeout;
`endif

    logic [10:0] b_len  [3];
    logic        b_wren [3];
    logic [7:0]  b_data [3];
    logic [9:0]  b_addr [3];
    logic        b_end  [3];

    assign iLen    = {b_len[2], b_len[1], b_len[0]};
    assign iWren   = {b_wren[2], b_wren[1], b_wren[0]};
    assign iData   = {b_data[2], b_data[1], b_data[0]};
    assign iAddr   = {b_addr[2], b_addr[1], b_addr[0]};
    assign iRunEnd = {b_end[2], b_end[1], b_end[0]};

    tx_frame_scheduler dut (
        .iDm9000aClk   (clk),
        .iRst_n        (rst_n),
        .iReq          (iReq),
        .iLen          (iLen),
        .oRunStart     (oRunStart),
        .iRunEnd       (iRunEnd),
        .iWren         (iWren),
        .iData         (iData),
        .iAddr         (iAddr),
        .wren_b        (wren_b),
        .data_b        (data_b),
        .address_b     (address_b),
        .oTxStart      (oTxStart),
        .oTxLen        (oTxLen),
        .iTxDone       (tx_done),
        .oBusy         (oBusy),
`ifdef TX_SCHED_WATCHDOG_EN
        .oBuildTimeout (oBuildTimeout),
`endif
        .oGrant        (oGrant)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic bitsel(input logic [2:0] v, input int i);
        logic [2:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int onehot_idx(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (bitsel(v, i)) return i;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Builder and TX engine behaviour
    int bcnt [3];
    int blen [3];
    bit arp_mode = 0, noise = 0, rand_blen = 0, spurious = 0;
    int dly_min = 1, dly_max = 3;
    bit tx_out = 0;
    int tx_cnt = 0;
    int gwr_cnt = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            b_len[i] = '0; b_wren[i] = 0; b_data[i] = '0; b_addr[i] = '0; b_end[i] = 0;
            bcnt[i] = 0; blen[i] = 4;
        end
        tx_done = 0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    bcnt[i] = 0; b_end[i] = 0; b_wren[i] = 0; b_addr[i] = '0; b_data[i] = '0;
                end else if (bitsel(oRunStart, i)) begin
                    bcnt[i]++;
                    if (rand_blen && bcnt[i] == 1) blen[i] = $urandom_range(1, 8);
                    b_end[i]  = (bcnt[i] >= blen[i]);
                    b_data[i] = 8'($urandom);
                    if (arp_mode && i == ARP_IDX) begin
                        b_wren[i] = (bcnt[i] >= 10 && bcnt[i] <= 37);
                        b_addr[i] = 10'(bcnt[i] + 4);
                    end else begin
                        b_wren[i] = 1'($urandom);
                        b_addr[i] = 10'($urandom_range(0, 1022));
                    end
                    if (b_wren[i]) gwr_cnt++;
                end else begin
                    bcnt[i]   = 0;
                    b_end[i]  = noise ? 1'($urandom) : 1'b0;
                    b_wren[i] = noise;
                    b_addr[i] = noise ? 10'h3FF : 10'h000;
                    b_data[i] = 8'($urandom);
                end
            end
            if (!rst_n) begin
                tx_out = 0; tx_done = 0;
            end else begin
                tx_done = 0;
                if (tx_out) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin tx_done = 1; tx_out = 0; end
                end else if (oTxStart) begin
                    tx_out = 1;
                    tx_cnt = $urandom_range(dly_min, dly_max);
                end else if (spurious && ($urandom % 16) == 0) begin
                    tx_done = 1;
                end
            end
        end
    end

    // Reference model and per-cycle compare
    int          m_phase = P_IDLE, m_owner = -1, m_last = N - 1;
    logic [2:0]  m_pend = '0;
    logic [10:0] m_len = '0;
    int          grant_log [$];
    int          txlen_log [$];
    int          wr_log    [$];
    int          run_rise_cyc = 0, runend_cyc = 0, busy_fall_cyc = 0;
    logic [2:0]  prev_run = '0;
    logic        prev_busy = 1'b0;
    logic [2:0]  e_run, e_grant;
    logic        e_wren;
    logic [7:0]  e_data;
    logic [9:0]  e_addr;
    int          w, c;

    initial forever begin
        @(negedge clk);
        if (oRunStart != 0 && prev_run == 0) begin
            grant_log.push_back(onehot_idx(oRunStart));
            run_rise_cyc = cyc;
        end
        if (oTxStart) txlen_log.push_back(int'(oTxLen));
        if (wren_b) wr_log.push_back(int'(address_b));
        if (prev_busy && !oBusy) busy_fall_cyc = cyc;
        prev_run  = oRunStart;
        prev_busy = oBusy;

        if (!rst_n) begin
            m_phase = P_IDLE; m_owner = -1; m_last = N - 1; m_pend = '0; m_len = '0;
            chk("rst_busy",  32'(oBusy),     32'(0));
            chk("rst_grant", 32'(oGrant),    32'(0));
            chk("rst_run",   32'(oRunStart), 32'(0));
            chk("rst_txst",  32'(oTxStart),  32'(0));
            chk("rst_txlen", 32'(oTxLen),    32'(0));
            chk("rst_wren",  32'(wren_b),    32'(0));
            chk("rst_addr",  32'(address_b), 32'(0));
            chk("rst_data",  32'(data_b),    32'(0));
        end else begin
            e_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            e_run   = (m_phase == P_BUILD) ? e_grant : 3'b000;
            e_wren  = 1'b0; e_data = '0; e_addr = '0;
            if (m_phase == P_BUILD) begin
                e_wren = b_wren[m_owner]; e_data = b_data[m_owner]; e_addr = b_addr[m_owner];
            end
            chk("busy",    32'(oBusy),     32'(m_phase != P_IDLE));
            chk("grant",   32'(oGrant),    32'(e_grant));
            chk("run",     32'(oRunStart), 32'(e_run));
            chk("txstart", 32'(oTxStart),  32'(m_phase == P_TX));
            chk("wren_b",  32'(wren_b),    32'(e_wren));
            chk("addr_b",  32'(address_b), 32'(e_addr));
            chk("data_b",  32'(data_b),    32'(e_data));
            if (m_phase == P_TX || m_phase == P_WAIT) chk("txlen", 32'(oTxLen), 32'(m_len));

            case (m_phase)
                P_IDLE: begin
                    w = -1;
                    for (int k = N; k >= 1; k--) begin
                        c = (m_last + k) % N;
                        if (m_pend[c[1:0]]) w = c;
                    end
                    if (w >= 0) begin
                        m_owner = w;
                        m_len   = b_len[w];
                        m_phase = P_BUILD;
                        m_pend  = m_pend & ~(3'b001 << w);
                    end
                end
                P_BUILD: if (b_end[m_owner]) begin m_phase = P_REL; runend_cyc = cyc; end
                P_REL: begin
                    if (m_len == 0) begin m_phase = P_IDLE; m_last = m_owner; m_owner = -1; end
                    else m_phase = P_TX;
                end
                P_TX: m_phase = P_WAIT;
                default: if (tx_done) begin m_phase = P_IDLE; m_last = m_owner; m_owner = -1; end
            endcase
            m_pend = m_pend | iReq;
        end
    end

    int req_cyc;

    task automatic pulse_req(input logic [2:0] v);
        @(posedge clk); #2;
        iReq = v;
        req_cyc = cyc;
        @(posedge clk); #2;
        iReq = 3'b000;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (m_phase == P_IDLE && m_pend == 0 && !oBusy) done = 1;
        end
        chk(nm, 32'(done), 32'(1));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic clear_logs();
        grant_log.delete(); txlen_log.delete(); wr_log.delete();
    endtask

    int hits, saved;
    bit seen;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        iReq = 3'b000;
        repeat (3) @(posedge clk);
        #3;
        chk("lit_rst_busy",  32'(oBusy),     32'(0));
        chk("lit_rst_grant", 32'(oGrant),    32'(0));
        chk("lit_rst_txlen", 32'(oTxLen),    32'(0));
        #2 rst_n = 1;

        // Single ARP frame
        arp_mode = 1; blen[ARP_IDX] = 56; dly_min = 3; dly_max = 3;
        b_len[ARP_IDX] = 11'd60;
        clear_logs();
        pulse_req(3'b001);
        wait_idle("arp_idle", 300);
        chk("arp_latency",  32'(run_rise_cyc - req_cyc), 32'(2));
        chk("arp_grants",   32'(grant_log.size()), 32'(1));
        chk("arp_txcount",  32'(txlen_log.size()), 32'(1));
        chk("arp_txlen",    32'(txlen_log.size() > 0 ? txlen_log[0] : -1), 32'(60));
        chk("arp_nwrites",  32'(wr_log.size()), 32'(28));
        chk("arp_first_wr", 32'(wr_log.size() > 0 ? wr_log[0] : -1), 32'(14));
        chk("arp_last_wr",  32'(wr_log.size() > 0 ? wr_log[wr_log.size()-1] : -1), 32'(41));
        chk("arp_grant_off", 32'(oGrant), 32'(0));
        arp_mode = 0;

        // Round-robin order from reset, then after serving index 2
        do_reset();
        b_len[ARP_IDX] = 11'd100; b_len[ICMP_IDX] = 11'd200; b_len[UDP_IDX] = 11'd300;
        for (int i = 0; i < 3; i++) blen[i] = 3;
        dly_min = 1; dly_max = 4;
        clear_logs();
        pulse_req(3'b111);
        wait_idle("rr1_idle", 300);
        chk("rr1_n",  32'(grant_log.size()), 32'(3));
        for (int i = 0; i < 3; i++) chk("rr1_order", 32'(i < grant_log.size() ? grant_log[i] : -1), 32'(i));
        chk("rr1_len2", 32'(txlen_log.size() > 2 ? txlen_log[2] : -1), 32'(300));
        clear_logs();
        pulse_req(3'b101);
        wait_idle("rr2_idle", 300);
        chk("rr2_n",  32'(grant_log.size()), 32'(2));
        chk("rr2_g0", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(0));
        chk("rr2_g1", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'(2));

        // Non-granted builders drive wren=1 / addr=3FF
        noise = 1; blen[ICMP_IDX] = 20; gwr_cnt = 0;
        clear_logs();
        pulse_req(3'b010);
        wait_idle("noise_idle", 300);
        hits = 0;
        foreach (wr_log[i]) if (wr_log[i] == 10'h3FF) hits++;
        chk("noise_3ff", 32'(hits), 32'(0));
        chk("noise_nwr", 32'(wr_log.size()), 32'(gwr_cnt));
        noise = 0;

        // Zero-length frame skips TX
        b_len[ICMP_IDX] = 11'd0; blen[ICMP_IDX] = 5;
        clear_logs();
        pulse_req(3'b010);
        wait_idle("zero_idle", 300);
        chk("zero_notx", 32'(txlen_log.size()), 32'(0));
        chk("zero_fall", 32'(busy_fall_cyc - runend_cyc > 0 && busy_fall_cyc - runend_cyc <= 3), 32'(1));

        // Reset during WAIT drops the frame and any pending request
        b_len[ICMP_IDX] = 11'd100; blen[ICMP_IDX] = 4; dly_min = 40; dly_max = 40;
        pulse_req(3'b010);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (oTxStart) seen = 1;
        end
        chk("mid_txstart_seen", 32'(seen), 32'(1));
        pulse_req(3'b100);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("mid_busy",  32'(oBusy),     32'(0));
        chk("mid_grant", 32'(oGrant),    32'(0));
        chk("mid_run",   32'(oRunStart), 32'(0));
        chk("mid_txlen", 32'(oTxLen),    32'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        saved = grant_log.size();
        repeat (30) @(posedge clk);
        #2;
        chk("mid_no_serve", 32'(grant_log.size()), 32'(saved));
        chk("mid_idle",     32'(oBusy),            32'(0));

        // Randomized traffic
        rand_blen = 1; noise = 1; spurious = 1; dly_min = 1; dly_max = 6;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #2;
            iReq = (($urandom % 4) == 0) ? 3'($urandom) : 3'b000;
            if (($urandom % 8) == 0) begin
                c = $urandom_range(0, 2);
                b_len[c] = (($urandom % 8) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
            end
        end
        @(posedge clk); #2;
        iReq = 3'b000;
        wait_idle("rand_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
